// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder.
// The FSM encoding, bus widths and address range check are defined here.
package dmem_pkg;

  localparam int WORD_W     = 32;
  localparam int BE_W       = 4;
  localparam int ADDR_HI_OK = 12;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic              we;
    logic [BE_W-1:0]   be;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } dmem_req_t;

  // Only the low 4 KB window is backed by storage.
  function automatic logic addr_in_range(input logic [WORD_W-1:0] addr);
    return addr[WORD_W-1:ADDR_HI_OK] == '0;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store handshake bus between the MEM stage (master) and the responder (slave).
interface dmem_responder_if;
  import dmem_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [BE_W-1:0]   req_be;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic              resp_valid;
  logic              resp_ready;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_be, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_we, req_be, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );

endinterface

// File: rtl/dmem_array.sv
// Word-addressed RAM with per-byte write enables and combinational read.
// Each byte lane owns its own storage array so lanes are written independently.
module dmem_array
  import dmem_pkg::*;
#(
  parameter int DEPTH_LOG2 = 10
) (
  input  logic                  clk,
  input  logic [BE_W-1:0]       we_be,
  input  logic [DEPTH_LOG2-1:0] idx,
  input  logic [WORD_W-1:0]     wdata,
  output logic [WORD_W-1:0]     rdata
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  for (genvar b = 0; b < BE_W; b++) begin : g_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (we_be[b]) mem[idx] <= wdata[8*b +: 8];
    end

    assign rdata[8*b +: 8] = mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency handshaked data memory: one request in flight, IDLE -> WAIT -> RESP.
// The RAM access happens on the edge entering RESP; results are held until the handshake.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int LATENCY    = 2,
  parameter int DEPTH_LOG2 = 10
) (
  input  logic              clk,
  input  logic              rst,
  dmem_responder_if.slave   bus,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE  = 2'(IDLE);
  localparam logic [1:0] ST_WAIT  = 2'(WAIT);
  localparam logic [1:0] ST_RESP  = 2'(RESP);
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  logic [1:0]        state;
  logic [3:0]        cnt;
  dmem_req_t         cap;
  dmem_req_t         live;
  dmem_req_t         acc;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [WORD_W-1:0] resp_rdata_q;
  logic              enter_resp;
  logic              acc_ok;
  logic [BE_W-1:0]   ram_we_be;
  logic [WORD_W-1:0] ram_rdata;

  assign live = '{we: bus.req_we, be: bus.req_be, addr: bus.req_addr, wdata: bus.req_wdata};

  // With LATENCY==1 the access edge is the accept edge, so use the live request.
  assign acc    = (state == ST_IDLE) ? live : cap;
  assign acc_ok = addr_in_range(acc.addr);

  assign enter_resp = !rst &&
                      (((state == ST_IDLE) && bus.req_valid && (LATENCY == 1)) ||
                       ((state == ST_WAIT) && (cnt == '0)));

  assign ram_we_be = (enter_resp && acc.we && acc_ok) ? acc.be : '0;

  dmem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
    .clk   (clk),
    .we_be (ram_we_be),
    .idx   (acc.addr[DEPTH_LOG2+1:2]),
    .wdata (acc.wdata),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      cap          <= '0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.req_valid) begin
            cap   <= live;
            cnt   <= CNT_INIT;
            state <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt == '0) state <= ST_RESP;
          else           cnt   <= cnt - 4'd1;
        end
        ST_RESP: begin
          if (bus.resp_ready) begin
            state        <= ST_IDLE;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (enter_resp) begin
        resp_valid_q <= 1'b1;
        resp_err_q   <= !acc_ok;
        resp_rdata_q <= (!acc.we && acc_ok) ? ram_rdata : '0;
      end
    end
  end

  assign bus.req_ready  = !rst && (state == ST_IDLE);
  assign bus.resp_valid = resp_valid_q;
  assign bus.resp_rdata = resp_rdata_q;
  assign bus.resp_err   = resp_err_q;
  assign busy           = (state != ST_IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: instance 0 at LATENCY=2, instance 1 at LATENCY=4.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic [1:0] rst;
  logic [1:0] rv, we, rr;
  logic [1:0][3:0]  be;
  logic [1:0][31:0] addr, wd;
  logic [1:0] rdy, vld, er, bsy;
  logic [1:0][31:0] rd;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dmem_responder_if b2 ();
  dmem_responder_if b4 ();

  assign b2.req_valid = rv[0];  assign b4.req_valid = rv[1];
  assign b2.req_we    = we[0];  assign b4.req_we    = we[1];
  assign b2.req_be    = be[0];  assign b4.req_be    = be[1];
  assign b2.req_addr  = addr[0]; assign b4.req_addr = addr[1];
  assign b2.req_wdata = wd[0];  assign b4.req_wdata = wd[1];
  assign b2.resp_ready = rr[0]; assign b4.resp_ready = rr[1];
  assign rdy = {b4.req_ready, b2.req_ready};
  assign vld = {b4.resp_valid, b2.resp_valid};
  assign er  = {b4.resp_err, b2.resp_err};
  assign rd  = {b4.resp_rdata, b2.resp_rdata};

  dmem_responder #(.LATENCY(2), .DEPTH_LOG2(10)) u_l2 (
    .clk(clk), .rst(rst[0]), .bus(b2.slave), .busy(bsy[0]));
  dmem_responder #(.LATENCY(4), .DEPTH_LOG2(10)) u_l4 (
    .clk(clk), .rst(rst[1]), .bus(b4.slave), .busy(bsy[1]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // One full transaction on instance k with resp_ready=1; lat = cycles from accept to resp_valid.
  task automatic xact(input int k, input logic w, input logic [3:0] bmask,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rdata, output logic err, output int lat);
    int guard = 0;
    rv[k] = 1'b1; we[k] = w; be[k] = bmask; addr[k] = a; wd[k] = d; rr[k] = 1'b1;
    while (!rdy[k] && guard < 40) begin tick(); guard++; end
    tick();
    rv[k] = 1'b0; we[k] = 1'b0; be[k] = '0; addr[k] = '0; wd[k] = '0;
    lat = 1;
    while (!vld[k] && lat < 40) begin tick(); lat++; end
    rdata = rd[k];
    err   = er[k];
    tick();
  endtask

  logic [31:0] r;
  logic e;
  int lat, n_acc, n_rsp, last_rsp;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 2'b11; rv = '0; we = '0; rr = '0; be = '0; addr = '0; wd = '0;
    tick(); tick();
    chk("rst_req_ready_l2", 32'(rdy[0]), 32'd0);
    chk("rst_req_ready_l4", 32'(rdy[1]), 32'd0);
    rst = 2'b00;
    #1;
    chk("idle_req_ready", 32'(rdy[0]), 32'd1);
    chk("idle_resp_valid", 32'(vld[0]), 32'd0);
    chk("idle_rdata", rd[0], 32'd0);
    chk("idle_err", 32'(er[0]), 32'd0);
    chk("idle_busy", 32'(bsy[0]), 32'd0);

    // Read-after-write
    xact(0, 1'b1, 4'b1111, 32'h10, 32'hDEADBEEF, r, e, lat);
    chk("st10_lat", 32'(lat), 32'd2);
    chk("st10_rdata", r, 32'd0);
    chk("st10_err", 32'(e), 32'd0);
    xact(0, 1'b0, 4'b0000, 32'h10, 32'h0, r, e, lat);
    chk("ld10_lat", 32'(lat), 32'd2);
    chk("ld10_rdata", r, 32'hDEADBEEF);

    // Empty byte mask: response returned, word untouched
    xact(0, 1'b1, 4'b0000, 32'h13, 32'h01234567, r, e, lat);
    chk("be0_err", 32'(e), 32'd0);
    xact(0, 1'b0, 4'b0000, 32'h10, 32'h0, r, e, lat);
    chk("be0_ld10", r, 32'hDEADBEEF);

    // Partial store
    xact(0, 1'b1, 4'b1111, 32'h20, 32'h11223344, r, e, lat);
    xact(0, 1'b1, 4'b0101, 32'h20, 32'hAABBCCDD, r, e, lat);
    xact(0, 1'b0, 4'b0000, 32'h22, 32'h0, r, e, lat);
    chk("partial_ld20", r, 32'h11BB33DD);

    // Range error
    xact(0, 1'b1, 4'b1111, 32'h4, 32'hCAFEF00D, r, e, lat);
    xact(0, 1'b1, 4'b1111, 32'h00001004, 32'h12345678, r, e, lat);
    chk("oor_st_err", 32'(e), 32'd1);
    chk("oor_st_rdata", r, 32'd0);
    xact(0, 1'b0, 4'b0000, 32'h4, 32'h0, r, e, lat);
    chk("oor_ld4", r, 32'hCAFEF00D);
    chk("oor_ld4_err", 32'(e), 32'd0);
    xact(0, 1'b0, 4'b0000, 32'h80000010, 32'h0, r, e, lat);
    chk("oor_ld_err", 32'(e), 32'd1);
    chk("oor_ld_rdata", r, 32'd0);

    // Back-pressure: hold resp_ready low for 4 response cycles
    rv[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10; rr[0] = 1'b0;
    tick();
    rv[0] = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("bp_valid", 32'(vld[0]), 32'd1);
      chk("bp_rdata", rd[0], 32'hDEADBEEF);
      chk("bp_req_ready", 32'(rdy[0]), 32'd0);
      tick();
    end
    chk("bp_valid_c6", 32'(vld[0]), 32'd1);
    rr[0] = 1'b1;
    tick();
    chk("bp_done_valid", 32'(vld[0]), 32'd0);
    chk("bp_done_ready", 32'(rdy[0]), 32'd1);
    chk("bp_done_busy", 32'(bsy[0]), 32'd0);

    // Held req_valid: one accept per IDLE visit, responses LATENCY+1 apart
    rv[0] = 1'b1; we[0] = 1'b0; addr[0] = 32'h10; rr[0] = 1'b1;
    n_acc = 0; n_rsp = 0; last_rsp = -1;
    for (int i = 0; i < 12; i++) begin
      if (rv[0] && rdy[0]) n_acc++;
      if (vld[0]) begin
        n_rsp++;
        chk("held_rdata", rd[0], 32'hDEADBEEF);
        if (last_rsp >= 0) chk("held_spacing", 32'(i - last_rsp), 32'd3);
        last_rsp = i;
      end
      tick();
    end
    rv[0] = 1'b0;
    #1;
    chk("held_accepts", 32'(n_acc), 32'd4);
    chk("held_resps", 32'(n_rsp), 32'd4);
    chk("held_end_busy", 32'(bsy[0]), 32'd0);

    // LATENCY=4: reset during WAIT discards the pending store
    xact(1, 1'b1, 4'b1111, 32'h30, 32'h0, r, e, lat);
    chk("l4_init_lat", 32'(lat), 32'd4);
    rv[1] = 1'b1; we[1] = 1'b1; be[1] = 4'b1111; addr[1] = 32'h30; wd[1] = 32'h5A5A5A5A;
    tick();
    rv[1] = 1'b0;
    tick();
    rst[1] = 1'b1;
    tick();
    rst[1] = 1'b0;
    #1;
    chk("l4_rst_busy", 32'(bsy[1]), 32'd0);
    chk("l4_rst_valid", 32'(vld[1]), 32'd0);
    tick(); tick(); tick();
    chk("l4_no_late_valid", 32'(vld[1]), 32'd0);
    xact(1, 1'b0, 4'b0000, 32'h30, 32'h0, r, e, lat);
    chk("l4_ld30_lat", 32'(lat), 32'd4);
    chk("l4_ld30_rdata", r, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
